// File: rtl/cc_level_sequencer_player_2.sv
// Level sequencer for player 2: drives the level/state code and the progress index into the
// level data handler, stepping through intro and play phases on a prescaled timer.
module cc_level_sequencer_player_2 #(
    parameter int unsigned CURRENTLEVEL_DATAWIDTH  = 3,
    parameter int unsigned LEVELPROGRESS_DATAWIDTH = 5,
    parameter int unsigned PRESCALER_DATAWIDTH     = 24,
    parameter int unsigned STEP_TICKS              = 12500000,
    parameter int unsigned INTRO_STEPS             = 4,
    parameter int unsigned CRASH_STEPS             = 3,
    parameter int unsigned LVL1_LENGTH             = 10,
    parameter int unsigned LVL2_LENGTH             = 15,
    parameter int unsigned LVL3_LENGTH             = 20
) (
    input  logic                               CC_LEVEL_SEQUENCER_PLAYER_2_CLOCK_50,
    input  logic                               CC_LEVEL_SEQUENCER_PLAYER_2_RESET_InLow,
    input  logic                               CC_LEVEL_SEQUENCER_PLAYER_2_Start_InLow,
    input  logic                               CC_LEVEL_SEQUENCER_PLAYER_2_Pause_InLow,
    input  logic                               CC_LEVEL_SEQUENCER_PLAYER_2_Crash_InLow,
    input  logic                               CC_LEVEL_SEQUENCER_PLAYER_2_Abort_InLow,
    output logic [CURRENTLEVEL_DATAWIDTH-1:0]  CC_LEVEL_SEQUENCER_PLAYER_2_CurrentLvl,
    output logic [LEVELPROGRESS_DATAWIDTH-1:0] CC_LEVEL_SEQUENCER_PLAYER_2_LvlProgress,
    output logic                               CC_LEVEL_SEQUENCER_PLAYER_2_LevelDone,
    output logic                               CC_LEVEL_SEQUENCER_PLAYER_2_GameWon
);

    localparam int unsigned IntroW = (INTRO_STEPS < 2) ? 1 : $clog2(INTRO_STEPS);
    localparam int unsigned HoldW  = $clog2(CRASH_STEPS + 1);
    localparam int unsigned ProgW  = LEVELPROGRESS_DATAWIDTH;
    localparam int unsigned PscW   = PRESCALER_DATAWIDTH;

    // The state code is the CurrentLvl value seen downstream.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StIntro1 = 3'd1,
        StPlay1  = 3'd2,
        StIntro2 = 3'd3,
        StPlay2  = 3'd4,
        StIntro3 = 3'd5,
        StPlay3  = 3'd6,
        StWon    = 3'd7
    } state_e;

    logic clk;
    logic rst_n;
    logic start;
    logic paused;
    logic crash;
    logic abort;

    assign clk    = CC_LEVEL_SEQUENCER_PLAYER_2_CLOCK_50;
    assign rst_n  = CC_LEVEL_SEQUENCER_PLAYER_2_RESET_InLow;
    assign start  = ~CC_LEVEL_SEQUENCER_PLAYER_2_Start_InLow;
    assign paused = ~CC_LEVEL_SEQUENCER_PLAYER_2_Pause_InLow;
    assign crash  = ~CC_LEVEL_SEQUENCER_PLAYER_2_Crash_InLow;
    assign abort  = ~CC_LEVEL_SEQUENCER_PLAYER_2_Abort_InLow;

    state_e             state_q, state_d;
    logic [ProgW-1:0]   prog_q, prog_d;
    logic [PscW-1:0]    presc_q, presc_d;
    logic [IntroW-1:0]  intro_q, intro_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic               done_q, done_d;
    logic               won_q, won_d;

    logic               in_intro;
    logic               in_play;
    logic               step;
    logic [ProgW-1:0]   level_len;

    assign in_intro = (state_q == StIntro1) || (state_q == StIntro2) || (state_q == StIntro3);
    assign in_play  = (state_q == StPlay1) || (state_q == StPlay2) || (state_q == StPlay3);
    assign step     = (in_intro || in_play) && (presc_q == PscW'(STEP_TICKS - 1));

    always_comb begin
        level_len = ProgW'(LVL3_LENGTH);
        if (state_q == StPlay1) begin
            level_len = ProgW'(LVL1_LENGTH);
        end else if (state_q == StPlay2) begin
            level_len = ProgW'(LVL2_LENGTH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            prog_q  <= '0;
            presc_q <= '0;
            intro_q <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
            won_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prog_q  <= prog_d;
            presc_q <= presc_d;
            intro_q <= intro_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            won_q   <= won_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        presc_d = presc_q;
        intro_d = intro_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = StIdle;
            prog_d  = '0;
            presc_d = '0;
            intro_d = '0;
            hold_d  = '0;
        end else if (!paused) begin
            if (in_intro || in_play) begin
                presc_d = step ? '0 : presc_q + 1'b1;
            end
            unique case (state_q)
                StIdle, StWon: begin
                    if (start) begin
                        state_d = StIntro1;
                        prog_d  = '0;
                    end
                end
                StIntro1, StIntro2, StIntro3: begin
                    if (step) begin
                        if (intro_q == IntroW'(INTRO_STEPS - 1)) begin
                            state_d = state_e'(state_q + 3'd1);
                            prog_d  = ProgW'(1);
                            intro_d = '0;
                        end else begin
                            intro_d = intro_q + 1'b1;
                        end
                    end
                end
                StPlay1, StPlay2, StPlay3: begin
                    // A crash load takes precedence over, and swallows, a coincident step.
                    if (crash) begin
                        hold_d = HoldW'(CRASH_STEPS);
                    end else if (step) begin
                        if (hold_q != '0) begin
                            hold_d = hold_q - 1'b1;
                        end else if (prog_q < level_len) begin
                            prog_d = prog_q + 1'b1;
                        end else begin
                            state_d = state_e'(state_q + 3'd1);
                            prog_d  = '0;
                            done_d  = 1'b1;
                        end
                    end
                end
            endcase
            if (state_d != state_q) begin
                presc_d = '0;
            end
        end
        won_d = (state_d == StWon);
    end

    always_comb begin
        CC_LEVEL_SEQUENCER_PLAYER_2_CurrentLvl  = CURRENTLEVEL_DATAWIDTH'(state_q);
        CC_LEVEL_SEQUENCER_PLAYER_2_LvlProgress = prog_q;
        CC_LEVEL_SEQUENCER_PLAYER_2_LevelDone   = done_q;
        CC_LEVEL_SEQUENCER_PLAYER_2_GameWon     = won_q;
    end

endmodule

// File: tb/tb_cc_level_sequencer_player_2.sv
// Bench for the player-2 level sequencer: phase-level reference model feeding a scoreboard queue,
// directed scenarios followed by randomized start/pause/crash/abort traffic.
module tb_cc_level_sequencer_player_2;

    localparam int unsigned StepTicks  = 4;
    localparam int unsigned IntroSteps = 2;
    localparam int unsigned CrashSteps = 3;
    localparam int unsigned Len1       = 10;
    localparam int unsigned Len2       = 15;
    localparam int unsigned Len3       = 20;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start_n = 1'b1;
    logic       pause_n = 1'b1;
    logic       crash_n = 1'b1;
    logic       abort_n = 1'b1;
    logic [2:0] lvl;
    logic [4:0] prog;
    logic       done;
    logic       won;

    int n_tests    = 0;
    int n_fail     = 0;
    int done_count = 0;

    cc_level_sequencer_player_2 #(
        .CURRENTLEVEL_DATAWIDTH (3),
        .LEVELPROGRESS_DATAWIDTH(5),
        .PRESCALER_DATAWIDTH    (24),
        .STEP_TICKS             (StepTicks),
        .INTRO_STEPS            (IntroSteps),
        .CRASH_STEPS            (CrashSteps),
        .LVL1_LENGTH            (Len1),
        .LVL2_LENGTH            (Len2),
        .LVL3_LENGTH            (Len3)
    ) dut (
        .CC_LEVEL_SEQUENCER_PLAYER_2_CLOCK_50   (clk),
        .CC_LEVEL_SEQUENCER_PLAYER_2_RESET_InLow(rst_n),
        .CC_LEVEL_SEQUENCER_PLAYER_2_Start_InLow(start_n),
        .CC_LEVEL_SEQUENCER_PLAYER_2_Pause_InLow(pause_n),
        .CC_LEVEL_SEQUENCER_PLAYER_2_Crash_InLow(crash_n),
        .CC_LEVEL_SEQUENCER_PLAYER_2_Abort_InLow(abort_n),
        .CC_LEVEL_SEQUENCER_PLAYER_2_CurrentLvl (lvl),
        .CC_LEVEL_SEQUENCER_PLAYER_2_LvlProgress(prog),
        .CC_LEVEL_SEQUENCER_PLAYER_2_LevelDone  (done),
        .CC_LEVEL_SEQUENCER_PLAYER_2_GameWon    (won)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: game phase + level number + clocks spent in the phase.
    typedef enum int {PhIdle, PhIntro, PhPlay, PhWon} phase_e;
    phase_e m_phase;
    int     m_lvl, m_prog, m_ticks, m_isteps, m_hold;
    bit     m_done;
    logic [9:0] exp_q[$];

    function automatic int len_of(input int l);
        return (l == 1) ? Len1 : (l == 2) ? Len2 : Len3;
    endfunction

    function automatic logic [9:0] expected();
        int code;
        case (m_phase)
            PhIdle:  code = 0;
            PhIntro: code = 2 * m_lvl - 1;
            PhPlay:  code = 2 * m_lvl;
            default: code = 7;
        endcase
        return {3'(code), 5'(m_prog), m_done, (m_phase == PhWon)};
    endfunction

    task automatic enter(input phase_e ph, input int l);
        m_phase  = ph;
        m_lvl    = l;
        m_ticks  = 0;
        m_isteps = 0;
        m_hold   = 0;
    endtask

    task automatic model_reset();
        enter(PhIdle, 1);
        m_prog = 0;
        m_done = 0;
    endtask

    task automatic model_step();
        bit step;
        step   = 0;
        m_done = 0;
        if (!abort_n) begin
            model_reset();
            return;
        end
        if (!pause_n) return;
        if (m_phase == PhIntro || m_phase == PhPlay) begin
            m_ticks++;
            step = (m_ticks % StepTicks) == 0;
        end
        case (m_phase)
            PhIdle, PhWon: if (!start_n) begin
                enter(PhIntro, 1);
                m_prog = 0;
            end
            PhIntro: if (step) begin
                m_isteps++;
                if (m_isteps == IntroSteps) begin
                    enter(PhPlay, m_lvl);
                    m_prog = 1;
                end
            end
            default: begin
                if (!crash_n) m_hold = CrashSteps;
                else if (step) begin
                    if (m_hold > 0) m_hold--;
                    else if (m_prog < len_of(m_lvl)) m_prog++;
                    else begin
                        m_done = 1;
                        m_prog = 0;
                        if (m_lvl == 3) enter(PhWon, 3);
                        else enter(PhIntro, m_lvl + 1);
                    end
                end
            end
        endcase
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
                exp_q.delete();
            end else begin
                model_step();
                exp_q.push_back(expected());
            end
        end
    end

    initial begin : monitor
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("cycle", {22'd0, lvl, prog, done, won}, {22'd0, e});
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && done) done_count++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start_n = 1'b0;
        @(negedge clk);
        start_n = 1'b1;
    endtask

    task automatic pulse_crash();
        crash_n = 1'b0;
        @(negedge clk);
        crash_n = 1'b1;
    endtask

    task automatic pulse_abort();
        abort_n = 1'b0;
        @(negedge clk);
        abort_n = 1'b1;
    endtask

    task automatic wait_for(input logic [2:0] code, input logic [4:0] p, input bit use_p,
                            input int budget, input string name);
        int k;
        k = 0;
        while (!(lvl == code && (!use_p || prog == p)) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, (lvl == code && (!use_p || prog == p))}, 32'd1);
    endtask

    initial begin : stimulus
        cyc(2);
        rst_n = 1'b1;
        #1 check("reset_outputs", {lvl, prog, done, won}, 10'd0);
        cyc(2);

        pulse_start();
        check("start_intro1", lvl, 3'd1);
        cyc(8);
        check("play1_entry", {lvl, prog}, {3'd2, 5'd1});
        cyc(4);
        check("play1_step", prog, 5'd2);

        // Second crash lands on a step edge and restarts the hold.
        wait_for(3'd2, 5'd5, 1'b1, 40, "reach_play1_p5");
        pulse_crash();
        cyc(6);
        pulse_crash();
        cyc(6);
        check("crash_hold", {lvl, prog}, {3'd2, 5'd5});
        wait_for(3'd2, 5'd6, 1'b1, 40, "crash_resume");

        wait_for(3'd4, 5'd4, 1'b1, 200, "reach_play2_p4");
        cyc(1);
        pause_n = 1'b0;
        cyc(5);
        start_n = 1'b0;
        cyc(1);
        start_n = 1'b1;
        cyc(14);
        check("pause_frozen", {lvl, prog, done}, {3'd4, 5'd4, 1'b0});
        pause_n = 1'b1;

        wait_for(3'd7, 5'd0, 1'b0, 400, "reach_won");
        #1 check("done_pulses", done_count, 32'd3);
        check("won_flag", {lvl, prog, won}, {3'd7, 5'd0, 1'b1});
        @(negedge clk);
        pulse_start();
        check("restart", {lvl, won}, {3'd1, 1'b0});

        wait_for(3'd5, 5'd0, 1'b0, 300, "reach_intro3");
        cyc(3);
        pulse_abort();
        check("abort_intro3", {lvl, prog, done}, 9'd0);

        pulse_start();
        wait_for(3'd6, 5'd0, 1'b0, 300, "reach_play3");
        cyc(9);
        pulse_abort();
        check("abort_play3", {lvl, prog, done}, 9'd0);

        pulse_start();
        wait_for(3'd2, 5'd0, 1'b0, 40, "reach_play1");
        pause_n = 1'b0;
        cyc(3);
        pulse_abort();
        check("abort_paused", {lvl, prog, done}, 9'd0);
        pause_n = 1'b1;

        pulse_start();
        wait_for(3'd4, 5'd7, 1'b1, 300, "reach_play2_p7");
        #1 rst_n = 1'b0;
        #1 check("async_reset", {lvl, prog, done, won}, 10'd0);
        cyc(2);
        rst_n = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start_n = start_n ? ($urandom_range(0, 24) != 0) : 1'b1;
            crash_n = crash_n ? ($urandom_range(0, 29) != 0) : 1'b1;
            abort_n = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 29) == 0) pause_n = ~pause_n;
        end
        start_n = 1'b1;
        crash_n = 1'b1;
        abort_n = 1'b1;
        pause_n = 1'b1;
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cc_level_sequencer_player_2.md
Name: cc_level_sequencer_player_2

Overview:
- Upstream feeder of the player-2 level data handler. Generates its CurrentLvl (3 bit) and LvlProgress (5 bit) inputs.
- A prescaled step timer advances progress through each level's length. Between levels the block inserts intro phases, then reports win or abort.
- Handles start, pause, crash-hold and abort from the player-2 game FSM.
- All outputs are registered.

Parameters:
- CURRENTLEVEL_DATAWIDTH, 3: width of the CurrentLvl output.
- LEVELPROGRESS_DATAWIDTH, 5: width of the LvlProgress output.
- PRESCALER_DATAWIDTH, 24: width of the prescaler counter.
- STEP_TICKS, 12500000: clocks per progress step. Must be >= 2.
- INTRO_STEPS, 4: steps spent in each intro state. Must be >= 1.
- CRASH_STEPS, 3: steps for which progress is frozen after a crash. Must be >= 1.
- LVL1_LENGTH, 10: last progress value of level 1.
- LVL2_LENGTH, 15: last progress value of level 2.
- LVL3_LENGTH, 20: last progress value of level 3. Must be <= 31.

Ports:
- CC_LEVEL_SEQUENCER_PLAYER_2_CLOCK_50  in  1  system clock; the only clock.
- CC_LEVEL_SEQUENCER_PLAYER_2_RESET_InLow  in  1  reset, asynchronous, active-low.
- CC_LEVEL_SEQUENCER_PLAYER_2_Start_InLow  in  1  start request. One-cycle pulse, active-low.
- CC_LEVEL_SEQUENCER_PLAYER_2_Pause_InLow  in  1  pause while held low.
- CC_LEVEL_SEQUENCER_PLAYER_2_Crash_InLow  in  1  crash event. One-cycle pulse, active-low.
- CC_LEVEL_SEQUENCER_PLAYER_2_Abort_InLow  in  1  game over; return to idle. Active-low.
- CC_LEVEL_SEQUENCER_PLAYER_2_CurrentLvl  out  CURRENTLEVEL_DATAWIDTH  level/state code.
- CC_LEVEL_SEQUENCER_PLAYER_2_LvlProgress  out  LEVELPROGRESS_DATAWIDTH  current progress index.
- CC_LEVEL_SEQUENCER_PLAYER_2_LevelDone  out  1  one-cycle pulse on leaving a play state.
- CC_LEVEL_SEQUENCER_PLAYER_2_GameWon  out  1  high while the block is in WON.

Behaviour:
- Reset values:
  - CurrentLvl=0, LvlProgress=0, LevelDone=0, GameWon=0.
  - Prescaler, intro counter and crash-hold counter all 0.
- State is encoded directly on CurrentLvl:
  - 0 IDLE
  - 1 INTRO1, 2 PLAY1
  - 3 INTRO2, 4 PLAY2
  - 5 INTRO3, 6 PLAY3
  - 7 WON
- Prescaler:
  - Runs only in states 1-6 while Pause is high.
  - Counts 0..STEP_TICKS-1 and wraps to 0.
  - At the terminal count it asserts an internal step for exactly that cycle.
  - Cleared to 0 on every state change.
  - Consequence: the first step of a state occurs STEP_TICKS clocks after entry.
- Priority, highest first:
  1. Reset.
  2. Abort low → IDLE. LvlProgress=0, all counters cleared, GameWon=0, no LevelDone. Applies from any state, including during pause.
  3. Pause low → every register holds. Start and Crash pulses are ignored (not queued).
  4. Normal transitions, below.
- IDLE: Start low → INTRO1, LvlProgress=0.
- INTROn (codes 1, 3, 5):
  - LvlProgress stays 0.
  - The intro counter increments on each step.
  - On the INTRO_STEPS-th step → PLAYn with LvlProgress=1 on the same edge; intro counter cleared.
- PLAYn (codes 2, 4, 6):
  - On a step with crash hold = 0:
    - If LvlProgress < LENGTHn: LvlProgress+1.
    - If LvlProgress == LENGTHn: go to the next INTRO (or WON from PLAY3), LvlProgress=0, LevelDone=1 for one cycle.
  - On a step with crash hold > 0: hold decrements by 1; LvlProgress unchanged.
- Crash:
  - A Crash pulse in a PLAY state loads hold=CRASH_STEPS. A crash during hold reloads it.
  - If a crash and a step occur in the same cycle, the load wins and the step is consumed.
  - Crash in any non-PLAY state is ignored.
- WON: GameWon=1, LvlProgress=0. Start low → INTRO1 with GameWon=0.
- Start while in states 1-6 is ignored.
- LvlProgress never exceeds LENGTHn and never shows a value outside 0..LENGTHn for the current level.
- Codes 1, 3, 5, 7 drive a downstream data handler output of 0 by design.

Test Plan:
Bench parameters: STEP_TICKS=4, INTRO_STEPS=2, CRASH_STEPS=3.
- Reset: release reset → all outputs 0. Assert reset mid-PLAY2 with LvlProgress=7 → outputs 0 immediately, without waiting for a clock edge.
- Start pulse:
  - CurrentLvl=1 next cycle.
  - 8 clocks later: CurrentLvl=2, LvlProgress=1.
  - Thereafter +1 every 4 clocks, reaching 10.
  - 4 clocks after reaching 10: CurrentLvl=3, LvlProgress=0, LevelDone high for exactly 1 cycle.
- Full run:
  - Levels 1→2→3 complete; LevelDone pulses exactly 3 times; CurrentLvl=7, GameWon=1.
  - Start pulse → CurrentLvl=1, GameWon=0.
- Crash in PLAY1 at LvlProgress=5 → progress stays 5 for 3 steps (12 clocks), then 6. A second crash during hold restarts the 3-step hold.
- Pause low for 20 clocks mid-PLAY2 → all outputs and prescaler frozen; resumes exactly where it stopped. Start pulse during pause → no effect.
- Abort low in INTRO3, in PLAY3, and while paused → next cycle CurrentLvl=0, LvlProgress=0, no LevelDone.
